// File: rtl/adder32_rr_sched_if.sv
// rtl/adder32_rr_sched_if.sv - request/operand/result bundle for the shared-adder scheduler (ADDER32_SCHED_OVF_EN adds carry/overflow)
interface adder32_rr_sched_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]    i_req;
    logic [32*N_REQ-1:0] i_a;
    logic [32*N_REQ-1:0] i_b;
    logic [N_REQ-1:0]    o_gnt;
    logic                o_valid;
    logic [31:0]         o_sum;
    logic [IDW-1:0]      o_id;
    logic                i_ready;
`ifdef ADDER32_SCHED_OVF_EN
    logic                o_cout;
    logic                o_ovf;

    modport slave (
        input  i_req, i_a, i_b, i_ready,
        output o_gnt, o_valid, o_sum, o_id, o_cout, o_ovf
    );
    modport master (
        output i_req, i_a, i_b, i_ready,
        input  o_gnt, o_valid, o_sum, o_id, o_cout, o_ovf
    );
`else
    modport slave (
        input  i_req, i_a, i_b, i_ready,
        output o_gnt, o_valid, o_sum, o_id
    );
    modport master (
        output i_req, i_a, i_b, i_ready,
        input  o_gnt, o_valid, o_sum, o_id
    );
`endif
endinterface

// File: rtl/adder32_rr_sched.sv
// rtl/adder32_rr_sched.sv - round-robin scheduler sharing one adder32 among N_REQ requesters (ADDER32_SCHED_OVF_EN adds o_cout/o_ovf)
module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
`ifdef ADDER32_SCHED_OVF_EN
    output logic        cout_o,
`endif
    output logic [31:0] sum_o
);
    logic [32:0] full_w;

    assign full_w = {1'b0, a_i} + {1'b0, b_i} + {32'b0, cin_i};
    assign sum_o  = full_w[31:0];
`ifdef ADDER32_SCHED_OVF_EN
    assign cout_o = full_w[32];
`endif
endmodule

module adder32_rr_sched #(
    parameter int N_REQ = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    adder32_rr_sched_if.slave   bus
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [31:0]    sum_q, sum_d;
    logic [IDW-1:0] id_q, id_d;
`ifdef ADDER32_SCHED_OVF_EN
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic           add_cout;
`endif

    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand_w;
    logic [IDW-1:0] ptr_next;
    logic           can_issue;
    logic           issue;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic [31:0]    add_sum;

    // Scan upward from the pointer with wrap; first live request wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand_w  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_w = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand_w >= (IDW+1)'(N_REQ)) begin
                cand_w = cand_w - (IDW+1)'(N_REQ);
            end
            if (!found && bus.i_req[cand_w[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand_w[IDW-1:0];
            end
        end
    end

    assign ptr_next  = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    assign can_issue = (state_q == S_EMPTY) || bus.i_ready;
    // Gating with reset keeps the grant low while reset is asserted.
    assign issue     = can_issue && found && i_rst_n;
    assign bus.o_gnt = issue ? (N_REQ'(1) << gnt_idx) : '0;

    assign op_a = bus.i_a[{gnt_idx, 5'b0} +: 32];
    assign op_b = bus.i_b[{gnt_idx, 5'b0} +: 32];

    adder32 u_adder (
        .a_i    (op_a),
        .b_i    (op_b),
        .cin_i  (1'b0),
`ifdef ADDER32_SCHED_OVF_EN
        .cout_o (add_cout),
`endif
        .sum_o  (add_sum)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        id_d    = id_q;
`ifdef ADDER32_SCHED_OVF_EN
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_EMPTY: begin
                if (issue) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.i_ready && !issue) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
        // Drain and reload may coincide; the new result replaces the old one without a bubble.
        if (issue) begin
            sum_d = add_sum;
            id_d  = gnt_idx;
            ptr_d = ptr_next;
`ifdef ADDER32_SCHED_OVF_EN
            cout_d = add_cout;
            ovf_d  = (op_a[31] == op_b[31]) && (add_sum[31] != op_a[31]);
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            sum_q   <= '0;
            id_q    <= '0;
`ifdef ADDER32_SCHED_OVF_EN
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
`ifdef ADDER32_SCHED_OVF_EN
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.o_valid = (state_q == S_FULL);
    assign bus.o_sum   = sum_q;
    assign bus.o_id    = id_q;
`ifdef ADDER32_SCHED_OVF_EN
    assign bus.o_cout  = cout_q;
    assign bus.o_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_adder32_rr_sched.sv
// tb/tb_adder32_rr_sched.sv - randomized check of adder32_rr_sched against a behavioural arbiter/adder model
module tb_adder32_rr_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder32_rr_sched_if #(.N_REQ(N)) bus ();

    adder32_rr_sched #(.N_REQ(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    bit          mv;
    logic [31:0] msum;
    int          mid;
    int          mptr;
    bit          mcout;
    bit          movf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        mv = 0; msum = '0; mid = 0; mptr = 0; mcout = 0; movf = 0;
    endtask

    function automatic int model_pick();
        if (!rst_n) return -1;
        if (mv && !bus.i_ready) return -1;
        for (int i = 0; i < N; i++) begin
            if (bus.i_req[(mptr + i) % N]) return (mptr + i) % N;
        end
        return -1;
    endfunction

    task automatic set_slot(input int k, input logic [31:0] a, input logic [31:0] b);
        bus.i_a[32*k +: 32] = a;
        bus.i_b[32*k +: 32] = b;
    endtask

    // Compare against the model at the negedge, then fold in the coming edge.
    task automatic tick_check();
        int k;
        logic [N-1:0] eg;
        @(negedge clk);
        k  = model_pick();
        eg = (k >= 0) ? N'(1 << k) : '0;
        chk("gnt", 32'(bus.o_gnt), 32'(eg));
        chk("valid", 32'(bus.o_valid), 32'(mv));
        if (mv) begin
            chk("sum", bus.o_sum, msum);
            chk("id", 32'(bus.o_id), 32'(mid));
`ifdef ADDER32_SCHED_OVF_EN
            chk("cout", 32'(bus.o_cout), 32'(mcout));
            chk("ovf", 32'(bus.o_ovf), 32'(movf));
`endif
        end
    endtask

    task automatic tick_adv();
        int k;
        logic [32:0] s;
        logic [31:0] a, b;
        k = model_pick();
        if (k >= 0) begin
            a = bus.i_a[32*k +: 32];
            b = bus.i_b[32*k +: 32];
            s = {1'b0, a} + {1'b0, b};
            mv = 1; msum = s[31:0]; mid = k; mptr = (k + 1) % N;
            mcout = s[32];
            movf  = (a[31] == b[31]) && (s[31] != a[31]);
        end else if (mv && bus.i_ready) begin
            mv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.i_req   = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom_range(0, 15));
        bus.i_ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                0:       set_slot(k, 32'hFFFF_FFFF, $urandom());
                1:       set_slot(k, 32'h7FFF_FFFF, 32'($urandom_range(0, 3)));
                default: set_slot(k, $urandom(), $urandom());
            endcase
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.i_req   = '0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_ready = 1'b1;
        model_reset();
        #1;

        // Reset with all requests up: grant suppressed, outputs cleared.
        rst_n     = 1'b0;
        bus.i_req = 4'b1111;
        set_slot(0, 32'd5, 32'd7);
        #1;
        chk("rst_gnt", 32'(bus.o_gnt), 32'h0);
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_sum", bus.o_sum, 32'h0);
        chk("rst_id", 32'(bus.o_id), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        tick_check();
        chk("first_gnt", 32'(bus.o_gnt), 32'h1);
        tick_adv();
        bus.i_req = '0;
        tick_check();
        chk("single_valid", 32'(bus.o_valid), 32'h1);
        chk("single_sum", bus.o_sum, 32'd12);
        chk("single_id", 32'(bus.o_id), 32'h0);
        tick_adv();
        tick_check();
        chk("drain_valid", 32'(bus.o_valid), 32'h0);
        tick_adv();

        // Fairness from a fresh pointer.
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) set_slot(k, 32'(32'h100 * (k + 1)), 32'(k + 1));
        bus.i_req   = 4'b1111;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_check();
            chk("fair_gnt", 32'(bus.o_gnt), 32'(1 << (i % 4)));
            if (i > 0) chk("fair_id", 32'(bus.o_id), 32'((i - 1) % 4));
            tick_adv();
        end

        // Backpressure holds the result and suppresses grants.
        bus.i_ready = 1'b0;
        bus.i_req   = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick_check();
            chk("bp_gnt", 32'(bus.o_gnt), 32'h0);
            chk("bp_sum", bus.o_sum, 32'h101);
            chk("bp_id", 32'(bus.o_id), 32'h0);
            tick_adv();
        end
        bus.i_ready = 1'b1;
        tick_check();
        chk("bp_release_gnt", 32'(bus.o_gnt), 32'h4);
        tick_adv();
        tick_check();
        chk("bp_new_id", 32'(bus.o_id), 32'h2);
        chk("bp_new_sum", bus.o_sum, 32'h303);

        // Wrap and flag cases.
        bus.i_req = 4'b0001;
        set_slot(0, 32'hFFFF_FFFF, 32'h1);
        tick_adv();
        set_slot(0, 32'h7FFF_FFFF, 32'h1);
        tick_check();
        chk("wrap_sum", bus.o_sum, 32'h0);
`ifdef ADDER32_SCHED_OVF_EN
        chk("wrap_cout", 32'(bus.o_cout), 32'h1);
        chk("wrap_ovf", 32'(bus.o_ovf), 32'h0);
`endif
        tick_adv();
        bus.i_req   = '0;
        bus.i_ready = 1'b0;
        tick_check();
        chk("ovf_sum", bus.o_sum, 32'h8000_0000);
`ifdef ADDER32_SCHED_OVF_EN
        chk("ovf_ovf", 32'(bus.o_ovf), 32'h1);
        chk("ovf_cout", 32'(bus.o_cout), 32'h0);
`endif

        // Asynchronous reset between edges while a result is held.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.o_valid), 32'h0);
        chk("async_sum", bus.o_sum, 32'h0);
        model_reset();
        rst_n       = 1'b1;
        bus.i_req   = 4'b1111;
        bus.i_ready = 1'b1;
        #0;
        chk("async_ptr_gnt", 32'(bus.o_gnt), 32'h1);
        tick_adv();

        for (int c = 0; c < 500; c++) begin
            rand_inputs();
            tick_check();
            tick_adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
